// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: registered two-source round-robin arbiter.
// Drives the select of the downstream 2:1 data mux.
// Captures the granted word into one output register with a valid/ready handshake.
// A per-grant burst limit keeps the two sources fair under continuous contention.
module mux_sel_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             rdy0,
    output logic             rdy1,
    output logic             s0,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    // Count value of the last transfer a grant may make while the other source waits
    localparam logic [7:0] LAST_COUNT = 8'(MAX_BURST - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_nextState;
    logic [7:0]       r_count;
    logic [7:0]       w_nextCount;
    logic             r_last;
    logic             r_s0;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;

    logic             w_space;
    logic             w_rdy0;
    logic             w_rdy1;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_burstEnd;

    assign w_space    = !r_outValid || out_ready;
    assign w_rdy0     = (r_state == GRANT0) && w_space;
    assign w_rdy1     = (r_state == GRANT1) && w_space;
    assign w_xfer0    = req0 && w_rdy0;
    assign w_xfer1    = req1 && w_rdy1;
    assign w_burstEnd = (r_count == LAST_COUNT);

    assign rdy0      = w_rdy0;
    assign rdy1      = w_rdy1;
    assign s0        = r_s0;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;

    // Next grant and burst count; the count only moves on an actual transfer
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        case (r_state)
            IDLE: begin
                w_nextCount = '0;
                if (req0 && req1) begin
                    w_nextState = r_last ? GRANT0 : GRANT1;
                end else if (req0) begin
                    w_nextState = GRANT0;
                end else if (req1) begin
                    w_nextState = GRANT1;
                end
            end
            GRANT0: begin
                if (w_xfer0) begin
                    if (w_burstEnd) begin
                        w_nextCount = '0;
                        if (req1) begin
                            w_nextState = GRANT1;
                        end
                    end else begin
                        w_nextCount = r_count + 8'd1;
                    end
                end else if (!req0) begin
                    w_nextCount = '0;
                    w_nextState = req1 ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (w_xfer1) begin
                    if (w_burstEnd) begin
                        w_nextCount = '0;
                        if (req0) begin
                            w_nextState = GRANT0;
                        end
                    end else begin
                        w_nextCount = r_count + 8'd1;
                    end
                end else if (!req1) begin
                    w_nextCount = '0;
                    w_nextState = req0 ? GRANT0 : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    // Grant state, burst count, select and round-robin history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_s0    <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_nextState == GRANT0) begin
                r_s0 <= 1'b0;
            end else if (w_nextState == GRANT1) begin
                r_s0 <= 1'b1;
            end
            if (w_xfer0) begin
                r_last <= 1'b0;
            end else if (w_xfer1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Output register: a load wins over a consume so back-to-back words flow at full rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else if (w_xfer0) begin
            r_outValid <= 1'b1;
            r_outData  <= d0;
        end else if (w_xfer1) begin
            r_outValid <= 1'b1;
            r_outData  <= d1;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
Registered two-source round-robin arbiter that sits directly upstream of the 2:1 data mux. It produces the mux select `s0` and gates which of two requesting sources, `d0` or `d1`, is transferred. The selected word is captured into a single output register with a valid/ready handshake toward the downstream consumer. A per-grant burst limit guarantees fairness when both sources request continuously.

Parameters:
- WIDTH, 8, data width of d0, d1, out_data.
- MAX_BURST, 4, max consecutive transfers from one source while the other is requesting; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  source 0 has a valid word on d0.
- req1  in  1  source 1 has a valid word on d1.
- d0  in  WIDTH  source 0 data.
- d1  in  WIDTH  source 1 data.
- rdy0  out  1  source 0 word accepted this cycle when req0 && rdy0.
- rdy1  out  1  source 1 word accepted this cycle when req1 && rdy1.
- s0  out  1  mux select: 0 = d0, 1 = d1.
- out_valid  out  1  out_data holds an unconsumed word.
- out_data  out  WIDTH  registered selected word.
- out_ready  in  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Reset (async assert, any time, including mid-burst):
  - FSM goes to IDLE; s0=0; out_valid=0; out_data=0; burst count=0; last_served=1 (source 0 wins first tie).
  - rdy0/rdy1 are 0 while rst is high.
  - Any pending output word is discarded.
- FSM states: IDLE, GRANT0, GRANT1. s0 is 1 in GRANT1 and 0 in GRANT0. In IDLE, s0 holds its previous value.
- IDLE:
  - req0 only -> GRANT0.
  - req1 only -> GRANT1.
  - Both -> grant the source != last_served.
  - Neither -> stay in IDLE.
  - IDLE never accepts data: one-cycle grant latency from first request.
- space = !out_valid || out_ready.
- rdy0 = (state==GRANT0) && space; rdy1 = (state==GRANT1) && space. Both are combinational; they are never high together.
- Transfer (req_i && rdy_i):
  - out_data <= d_i; out_valid <= 1; burst count increments; last_served <= i.
- Output register:
  - Consumption without a new transfer clears out_valid.
  - Consumption and a transfer in the same cycle: out_valid stays 1 and out_data is replaced. Full throughput is 1 word/cycle.
  - out_data holds its value while out_valid && !out_ready.
- Grant exit from GRANTi (evaluated each cycle, next state):
  - Transfer with count == MAX_BURST-1 and the other source requesting -> GRANT(other), count <= 0. No idle bubble.
  - Transfer with count == MAX_BURST-1 and the other source idle -> stay in GRANTi, count <= 0.
  - req_i low and the other requesting -> GRANT(other), count <= 0.
  - req_i low and the other idle -> IDLE, count <= 0.
  - Otherwise stay in GRANTi.
- Backpressure: while out_valid && !out_ready, no transfer occurs and the burst count is frozen. Grant may still move if req_i drops.
- Count register width: 8 bits; it never exceeds MAX_BURST-1.
- Source contract: a source must hold req_i and d_i stable until accepted. The arbiter does not check this.

Test Plan:
- Reset/idle: assert rst mid-transfer with out_valid=1 -> next sample shows out_valid=0, out_data=0, s0=0, rdy0=rdy1=0. After release with no requests, state stays IDLE.
- Single source streaming: req0=1, d0 counting 1,2,3…, out_ready=1 -> rdy0 high from cycle 2, out_data 1,2,3… one per cycle, s0=0 throughout, no forced switch.
- Contention fairness, MAX_BURST=4: req0=req1=1 constantly, out_ready=1 -> first grant goes to source 0. Sequence is 4 words from d0, then 4 from d1, alternating. s0 toggles on the cycle after each 4th transfer; there is no bubble in out_valid.
- Backpressure: stream from d1, hold out_ready=0 for 3 cycles -> rdy1=0 and out_data/out_valid frozen. Burst count is not advanced, and the total of 4 d1 words per burst is preserved on resume.
- Grant drop: in GRANT0 with req1=1, drop req0 -> next cycle state is GRANT1, s0=1, rdy1=1. If req1=0 instead, state returns to IDLE and s0 stays 0.
- Simultaneous consume/load: out_valid=1, out_ready=1, req0 accepted with d0=8'hA5 -> out_valid remains 1 and out_data=8'hA5 on the next cycle.
